fetch_queue: RTL and testbench

Dual-issue instruction fetch queue that sits directly upstream of decode (S0). It fetches instruction pairs from instruction memory and buffers them in a small FIFO of pairs. It presents the head pair to S0 as the P0/P1 slots and advances only when the hazard control unit's `fetch_next` allows. Branch redirects from execute flush the queue and any in-flight fetch.

---
 rtl/fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue -- dual-issue instruction fetch queue feeding decode stage S0.
//
// Fetches 32-bit instruction pairs from instruction memory. Each pair holds
// two 16-bit words. Pairs are buffered in a small FIFO. The head pair is
// presented to S0 as slots P0 (older) and P1 (younger). The head advances
// when the hazard unit raises fetch_next. A redirect from execute flushes the
// queue and any in-flight fetch, then restarts fetch at redirect_pc.
//
// Parameters:
//   QDEPTH   : queue capacity in pairs (power of 2, >= 2)
//   PC_W     : PC width in 16-bit words
//   RESET_PC : first fetch address after reset
//
// Ports:
//   clk, rst_n             : clock (rising edge); asynchronous active-low reset
//   imem_req, imem_addr    : fetch request and pair address
//   imem_rdata             : response, valid one cycle after imem_req
//                            ([15:0] = word at addr, [31:16] = word at addr+1)
//   fetch_next             : S0 consumes the presented pair this cycle
//   redirect, redirect_pc  : flush and restart fetch at redirect_pc
//   p0_instr, p0_pc        : older instruction of the head pair
//   p1_instr, p1_pc        : younger instruction of the head pair
//   pair_valid             : head pair present (covers both slots)
//
// Build option:
//   FETCHQ_BYPASS_EN : when defined, a response that arrives while the queue
//                      is empty is shown on the outputs in its arrival cycle.
//                      If S0 consumes it in that cycle, it is never written.

module fetch_queue #(
    parameter int              QDEPTH   = 4,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            fetch_next,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     p0_instr,
    output logic [PC_W-1:0] p0_pc,
    output logic [15:0]     p1_instr,
    output logic [PC_W-1:0] p1_pc,
    output logic            pair_valid
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(QDEPTH);
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
    localparam logic [PC_W-1:0]  PC_TWO    = PC_W'(2);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Control state
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PC_W-1:0]  pc_reg, pc_next;
    logic [PC_W-1:0]  resp_pc_reg, resp_pc_next;
    logic             inflight_reg, inflight_next;
    logic             kill_reg, kill_next;
    logic             run_reg;

    // Pair storage: full 32-bit pair word plus the pc of its first word.
    logic [31:0]     data_mem [QDEPTH];
    logic [PC_W-1:0] pcs_mem  [QDEPTH];

    logic            resp_ok;
    logic            queue_valid;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [CNT_W:0]  occupancy;
    logic [31:0]     head_data;
    logic [PC_W-1:0] head_pc;

    // A response is usable when one is due this cycle, it has not been
    // marked for discard, and no redirect is flushing the queue right now.
    assign resp_ok     = inflight_reg & ~kill_reg & ~redirect;
    assign queue_valid = (count_reg != '0);

    // Occupancy counts the outstanding request as a reserved slot. The pop
    // of this cycle is deliberately not credited, which keeps the request
    // path independent of fetch_next.
    assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign imem_req  = run_reg & ~redirect & (occupancy < DEPTH_OCC);
    assign imem_addr = pc_reg;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = resp_ok & ~queue_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pair_valid = queue_valid | bypass;

    // Queue pop only touches stored entries; a bypassed pair consumed in its
    // arrival cycle is simply never written.
    assign pop  = fetch_next & queue_valid & ~redirect;
    assign push = resp_ok & ~(bypass & fetch_next);

    always_comb begin
        head_data = data_mem[head_reg];
        head_pc   = pcs_mem[head_reg];
        if (bypass) begin
            head_data = imem_rdata;
            head_pc   = resp_pc_reg;
        end
    end

    assign p0_instr = pair_valid ? head_data[15:0]    : 16'h0000;
    assign p1_instr = pair_valid ? head_data[31:16]   : 16'h0000;
    assign p0_pc    = pair_valid ? head_pc            : '0;
    assign p1_pc    = pair_valid ? (head_pc + PC_ONE) : '0;

    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        pc_next       = pc_reg;
        resp_pc_next  = resp_pc_reg;
        inflight_next = imem_req;
        // The outstanding response of a redirect cycle lands in that same
        // cycle and is already dropped by redirect priority; kill also guards
        // the cycle after, so no stale data can slip in behind a flush.
        kill_next     = redirect & inflight_reg;

        if (redirect) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            pc_next    = redirect_pc;
        end else begin
            if (imem_req) begin
                pc_next      = pc_reg + PC_TWO;
                resp_pc_next = pc_reg;
            end
            if (push) begin
                tail_next = tail_reg + PTR_ONE;
            end
            if (pop) begin
                head_next = head_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            pc_reg       <= RESET_PC;
            resp_pc_reg  <= '0;
            inflight_reg <= 1'b0;
            kill_reg     <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            pc_reg       <= pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            kill_reg     <= kill_next;
            run_reg      <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_reg] <= imem_rdata;
            pcs_mem[tail_reg]  <= resp_pc_reg;
        end
    end

    // The request credit rule should make this unreachable.
    push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_reg == DEPTH_CNT));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (default build, bypass disabled).
// Memory model: the word at address i holds value i, so each pair fetched
// from address a returns {a+1, a}, with 8-bit address wrap.

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        fetch_next;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] p0_instr;
    logic [7:0]  p0_pc;
    logic [15:0] p1_instr;
    logic [7:0]  p1_pc;
    logic        pair_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .QDEPTH   (4),
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .fetch_next  (fetch_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .p0_instr    (p0_instr),
        .p0_pc       (p0_pc),
        .p1_instr    (p1_instr),
        .p1_pc       (p1_pc),
        .pair_valid  (pair_valid)
    );

    // Instruction memory: one-cycle response to whatever address is driven.
    always @(posedge clk) begin
        imem_rdata <= {8'h00, imem_addr + 8'd1, 8'h00, imem_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge, drive inputs for the coming posedge,
    // then let combinational outputs settle before checking.
    task automatic cyc(input logic fn, input logic rd, input logic [7:0] rpc);
        @(negedge clk);
        fetch_next  = fn;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [7:0] pc);
        logic [7:0] pc1;
        pc1 = pc + 8'd1;
        check({tag, "_valid"}, {31'd0, pair_valid}, 32'd1);
        check({tag, "_p0_pc"}, {24'd0, p0_pc}, {24'd0, pc});
        check({tag, "_p0_instr"}, {16'd0, p0_instr}, {24'd0, pc});
        check({tag, "_p1_pc"}, {24'd0, p1_pc}, {24'd0, pc1});
        check({tag, "_p1_instr"}, {16'd0, p1_instr}, {24'd0, pc1});
        $display("pair %s p0=%04h@%02h p1=%04h@%02h", tag, p0_instr, p0_pc, p1_instr, p1_pc);
    endtask

    initial begin
        fetch_next  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'h00);
        check("rst_valid", {31'd0, pair_valid}, 32'd0);
        check("rst_p0_instr", {16'd0, p0_instr}, 32'd0);
        check("rst_p1_pc", {24'd0, p1_pc}, 32'd0);
        rst_n = 1'b1;

        // Startup with S0 stalled: queue fills, requests stop at capacity
        cyc(1'b0, 1'b0, 8'h00);                            // C0
        check("c0_req", {31'd0, imem_req}, 32'd1);
        check("c0_addr", {24'd0, imem_addr}, 32'h00);
        check("c0_valid", {31'd0, pair_valid}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00);                            // C1
        check("c1_addr", {24'd0, imem_addr}, 32'h02);
        check("c1_valid", {31'd0, pair_valid}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00);                            // C2
        check_pair("c2", 8'h00);
        check("c2_addr", {24'd0, imem_addr}, 32'h04);
        cyc(1'b0, 1'b0, 8'h00);                            // C3
        check("c3_req", {31'd0, imem_req}, 32'd1);
        check("c3_addr", {24'd0, imem_addr}, 32'h06);
        cyc(1'b0, 1'b0, 8'h00);                            // C4
        check("c4_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 8'h00);                            // C5
        check("c5_req", {31'd0, imem_req}, 32'd0);
        check_pair("c5_hold", 8'h00);

        // Release: pop not credited in the first cycle, then stream
        cyc(1'b1, 1'b0, 8'h00);                            // C6
        check_pair("c6", 8'h00);
        check("c6_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 8'h00);                            // C7
        check_pair("c7", 8'h02);
        check("c7_addr", {24'd0, imem_addr}, 32'h08);
        for (int k = 2; k < 10; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'(2 * k);
            cyc(1'b1, 1'b0, 8'h00);
            check_pair("stream", exp_pc);
        end

        // Redirect to 0xFF: pc and address wrap
        cyc(1'b1, 1'b1, 8'hFF);                            // R
        check("wr_r_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, 8'h00);                            // R+1
        check("wr_r1_valid", {31'd0, pair_valid}, 32'd0);
        check("wr_r1_req", {31'd0, imem_req}, 32'd1);
        check("wr_r1_addr", {24'd0, imem_addr}, 32'hFF);
        cyc(1'b1, 1'b0, 8'h00);                            // R+2
        check("wr_r2_valid", {31'd0, pair_valid}, 32'd0);
        check("wr_r2_addr", {24'd0, imem_addr}, 32'h01);
        cyc(1'b1, 1'b0, 8'h00);                            // R+3
        check_pair("wr_r3", 8'hFF);
        cyc(1'b1, 1'b0, 8'h00);                            // R+4
        check_pair("wr_r4", 8'h01);

        // Fill the queue, then pull reset low mid-cycle
        repeat (6) cyc(1'b0, 1'b0, 8'h00);
        check("full_req", {31'd0, imem_req}, 32'd0);
        check_pair("full_head", 8'h03);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, pair_valid}, 32'd0);
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", {24'd0, imem_addr}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart at RESET_PC, then redirect with a response and
        // fetch_next in the same cycle while the 0x06 fetch is in flight
        cyc(1'b1, 1'b0, 8'h00);                            // C0
        check("rs_c0_req", {31'd0, imem_req}, 32'd1);
        check("rs_c0_addr", {24'd0, imem_addr}, 32'h00);
        check("rs_c0_valid", {31'd0, pair_valid}, 32'd0);
        cyc(1'b1, 1'b0, 8'h00);                            // C1
        check("rs_c1_addr", {24'd0, imem_addr}, 32'h02);
        cyc(1'b1, 1'b0, 8'h00);                            // C2
        check_pair("rs_c2", 8'h00);
        check("rs_c2_addr", {24'd0, imem_addr}, 32'h04);
        cyc(1'b1, 1'b0, 8'h00);                            // C3
        check_pair("rs_c3", 8'h02);
        check("rs_c3_addr", {24'd0, imem_addr}, 32'h06);
        cyc(1'b1, 1'b1, 8'h40);                            // C4 = R
        check("rd_r_req", {31'd0, imem_req}, 32'd0);
        check_pair("rd_r", 8'h04);
        cyc(1'b1, 1'b0, 8'h00);                            // R+1
        check("rd_r1_valid", {31'd0, pair_valid}, 32'd0);
        check("rd_r1_req", {31'd0, imem_req}, 32'd1);
        check("rd_r1_addr", {24'd0, imem_addr}, 32'h40);
        cyc(1'b1, 1'b0, 8'h00);                            // R+2
        check("rd_r2_valid", {31'd0, pair_valid}, 32'd0);
        check("rd_r2_addr", {24'd0, imem_addr}, 32'h42);
        cyc(1'b1, 1'b0, 8'h00);                            // R+3
        check_pair("rd_r3", 8'h40);
        cyc(1'b1, 1'b0, 8'h00);                            // R+4
        check_pair("rd_r4", 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
